// File: rtl/wu_burst_sched.sv
// Wake-up burst sequencer: synchronizes the comparator, arms on a qualified rising
// edge and plays out guard, preamble and payload bits onto the T_0/T_1 modulator controls.
module wu_burst_sched #(
  parameter int unsigned CLK_DIV       = 100,
  parameter int unsigned GUARD_BITS    = 8,
  parameter int unsigned PREAMBLE_BITS = 192,
  parameter int unsigned PAYLOAD_BITS  = 808
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       comp_out,
  input  logic       WU_valid,
  input  logic       arm,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic       T_0,
  output logic       T_1,
  output logic       data_clk_enb,
  output logic       busy,
  output logic [1:0] phase,
  output logic       done,
  output logic       abort
);

  // state    | meaning
  // IDLE     | waiting for a qualified comparator edge
  // GUARD    | leading bits, both controls low
  // PREAMBLE | alternating T_1 starting with 1
  // PAYLOAD  | prefetched bytes shifted out MSB first
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GUARD    = 2'd1;
  localparam logic [1:0] ST_PREAMBLE = 2'd2;
  localparam logic [1:0] ST_PAYLOAD  = 2'd3;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_BITS - 1);
  localparam logic [15:0] PRE_LAST   = 16'(PREAMBLE_BITS - 1);
  localparam logic [15:0] PAY_LAST   = 16'(PAYLOAD_BITS - 1);

  logic [2:0]  sync_buf;
  logic [1:0]  state;
  logic [15:0] div_cnt;
  logic [15:0] bit_cnt;
  logic [7:0]  pf_data;
  logic [7:0]  shift_reg;
  logic        pf_full;

  logic comp_edge;
  logic trigger;
  logic bit_end;
  logic byte_bound;
  logic pf_accept;

  assign comp_edge = (sync_buf[2:1] == 2'b01);
  assign trigger   = comp_edge & WU_valid & arm & (state == ST_IDLE);
  assign bit_end   = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  assign pf_accept = pl_valid & ~pf_full;

  // Byte boundary is the start of the next payload bit whose index is a multiple of 8.
  assign byte_bound = bit_end &&
                      (((state == ST_PREAMBLE) && (bit_cnt == PRE_LAST)) ||
                       ((state == ST_PAYLOAD) && (bit_cnt[2:0] == 3'd7) &&
                        (bit_cnt != PAY_LAST)));

  assign pl_ready     = ~pf_full;
  assign busy         = (state != ST_IDLE);
  assign data_clk_enb = busy;
  assign phase        = state;

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      sync_buf  <= 3'b000;
      state     <= ST_IDLE;
      div_cnt   <= 16'd0;
      bit_cnt   <= 16'd0;
      pf_data   <= 8'd0;
      shift_reg <= 8'd0;
      pf_full   <= 1'b0;
      T_0       <= 1'b0;
      T_1       <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      sync_buf <= {sync_buf[1:0], comp_out};
      done     <= 1'b0;
      abort    <= 1'b0;

      if (pf_accept) begin
        pf_data <= pl_data;
        pf_full <= 1'b1;
      end

      if (trigger) begin
        state   <= ST_GUARD;
        div_cnt <= 16'd0;
        bit_cnt <= 16'd0;
        T_0     <= 1'b0;
        T_1     <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (!bit_end) begin
          div_cnt <= div_cnt + 16'd1;
        end else begin
          div_cnt <= 16'd0;
          bit_cnt <= bit_cnt + 16'd1;
          case (state)
            ST_GUARD: begin
              if (bit_cnt == GUARD_LAST) begin
                state   <= ST_PREAMBLE;
                bit_cnt <= 16'd0;
                T_1     <= 1'b1;
                T_0     <= 1'b0;
              end
            end
            ST_PREAMBLE: begin
              if (bit_cnt == PRE_LAST) bit_cnt <= 16'd0;
              else T_1 <= bit_cnt[0];
            end
            ST_PAYLOAD: begin
              if (bit_cnt == PAY_LAST) begin
                state   <= ST_IDLE;
                bit_cnt <= 16'd0;
                done    <= 1'b1;
                T_0     <= 1'b0;
                T_1     <= 1'b0;
              end else if (bit_cnt[2:0] != 3'd7) begin
                T_1       <= shift_reg[7];
                T_0       <= ~shift_reg[7];
                shift_reg <= {shift_reg[6:0], 1'b0};
              end
            end
            default: ;
          endcase

          // Byte boundary: consume the prefetch or abandon the burst on underrun.
          if (byte_bound) begin
            if (!pf_full) begin
              state   <= ST_IDLE;
              bit_cnt <= 16'd0;
              abort   <= 1'b1;
              T_0     <= 1'b0;
              T_1     <= 1'b0;
              pf_full <= 1'b0;
            end else begin
              state     <= ST_PAYLOAD;
              shift_reg <= {pf_data[6:0], 1'b0};
              T_1       <= pf_data[7];
              T_0       <= ~pf_data[7];
              pf_full   <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule
